// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among num_req valid/ready producers.
// Optional FIFO_ARB_STATS_EN adds a saturating stall_count output.
module fifo_wr_arbiter #(
  parameter int width     = 8,
  parameter int depth     = 8,
  parameter int num_req   = 4,
  parameter int max_burst = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [num_req-1:0]         req_valid,
  input  logic [num_req*width-1:0]   req_data,
  output logic [num_req-1:0]         req_ready,
  input  logic [$clog2(depth):0]     fifo_data_count,
  output logic                       fifo_wrEn,
  output logic [width-1:0]           fifo_wrData,
  output logic [$clog2(num_req)-1:0] grant_id,
  output logic                       busy
`ifdef FIFO_ARB_STATS_EN
  , output logic [15:0]              stall_count
`endif
);

  localparam int CW = $clog2(depth) + 1;
  localparam int GW = $clog2(num_req);
  localparam int BW = $clog2(max_burst) + 1;
  localparam logic [BW-1:0] BURST_LAST = BW'(max_burst - 1);
  localparam logic [CW:0]   DEPTH_V    = (CW+1)'(depth);

  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_nxt;

  logic [GW-1:0] last_grant, rr_sel;
  logic          rr_hit;
  logic [BW-1:0] burst_cnt;
  logic [CW:0]   occ;
  logic          space, cur_valid, xfer, release_g;

  // The registered write still in flight counts as occupied.
  assign occ       = {1'b0, fifo_data_count} + {{CW{1'b0}}, fifo_wrEn};
  assign space     = occ < DEPTH_V;
  assign cur_valid = req_valid[grant_id];
  assign busy      = (state == GRANT);

  // Scan downward so the nearest requester after last_grant wins.
  always_comb begin
    int idx;
    rr_sel = '0;
    rr_hit = 1'b0;
    idx    = 0;
    for (int k = num_req; k >= 1; k--) begin
      idx = (int'(last_grant) + k) % num_req;
      if (req_valid[GW'(idx)]) begin
        rr_sel = GW'(idx);
        rr_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    xfer      = 1'b0;
    release_g = 1'b0;
    case (state)
      IDLE: if (rr_hit) state_nxt = GRANT;
      GRANT: begin
        req_ready[grant_id] = space;
        xfer      = cur_valid && space;
        release_g = !cur_valid || (xfer && burst_cnt == BURST_LAST);
        if (release_g) state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fifo_wrEn   <= 1'b0;
      fifo_wrData <= '0;
      grant_id    <= '0;
      burst_cnt   <= '0;
      last_grant  <= GW'(num_req - 1);
    end else begin
      fifo_wrEn <= xfer;
      if (xfer) begin
        fifo_wrData <= req_data[grant_id*width +: width];
        burst_cnt   <= burst_cnt + 1'b1;
      end
      if (state == IDLE && rr_hit) begin
        grant_id  <= rr_sel;
        burst_cnt <= '0;
      end
      if (release_g) last_grant <= grant_id;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset)
      stall_count <= '0;
    else if (busy && cur_valid && !space && stall_count != 16'hFFFF)
      stall_count <= stall_count + 16'd1;
  end
`endif

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares one synchronous FIFO write port among `num_req` producers. Each producer uses a valid/ready handshake. The arbiter grants one producer at a time for a bounded burst and forwards accepted words to the FIFO as a registered write strobe plus data. Backpressure is computed from the FIFO's `data_count`, and the in-flight registered write is included so the FIFO is never overrun.

## Interface
Parameters:
- `width`, 8, data word width in bits
- `depth`, 8, depth of the downstream FIFO; sets the `fifo_data_count` width and the full threshold
- `num_req`, 4, number of producers (≥2)
- `max_burst`, 4, maximum words accepted per grant (≥1)

Ports:
- `clk`, input, 1, clock
- `reset`, input, 1, reset: synchronous, active-high
- `req_valid`, input, `num_req`, bit i set when producer i presents a word
- `req_data`, input, `num_req*width`, producer i's word in bits `[i*width +: width]`
- `req_ready`, output, `num_req`, bit i set when producer i's word is accepted this cycle (combinational)
- `fifo_data_count`, input, `$clog2(depth)+1`, FIFO occupancy
- `fifo_wrEn`, output, 1, registered write strobe to the FIFO
- `fifo_wrData`, output, `width`, registered write data to the FIFO
- `grant_id`, output, `$clog2(num_req)`, currently or most recently granted producer
- `busy`, output, 1, high while in the GRANT state

## Operation
- State machine has two states: IDLE and GRANT.
- **IDLE:**
  - If any `req_valid` bit is set, select the first valid requester scanning upward from `last_grant+1` (mod `num_req`).
  - Register the selection into `grant_id`, clear `burst_cnt`, and go to GRANT.
  - If no bit is set, stay in IDLE.
- **Space check:** `space = (fifo_data_count + fifo_wrEn) < depth`. The currently asserted `fifo_wrEn` counts as one pending word.
- **Ready:** `req_ready[i] = (state==GRANT) && (grant_id==i) && space`. All other ready bits are 0.
- **Transfer:** a transfer occurs when `req_valid[grant_id] && req_ready[grant_id]`. On a transfer:
  - `fifo_wrData <= req_data[grant_id]` and `fifo_wrEn <= 1`.
  - `burst_cnt` increments.
- **No transfer:** `fifo_wrEn <= 0`. `fifo_wrData` holds its value.
- **Release from GRANT to IDLE** when either:
  - a transfer occurs and `burst_cnt == max_burst-1` (burst limit reached), or
  - `req_valid[grant_id] == 0` in a cycle (producer dropped).
  - On release, `last_grant <= grant_id`.
- **Stall:** when `!space` and valid is held, the arbiter stays in GRANT with ready low. A stalled cycle does not count toward the burst.
- **Arithmetic:** `burst_cnt` is `$clog2(max_burst)+1` bits wide. The space sum is computed one bit wider than `fifo_data_count` so it cannot overflow.
- **Wrap-around:** the round-robin scan wraps from `num_req-1` to 0. A lone valid requester is regranted after each release.

## Timing
- **Reset** (synchronous, takes effect at the next clk edge):
  - Registered state: state=IDLE, `fifo_wrEn`=0, `fifo_wrData`=0, `grant_id`=0, `busy`=0, `burst_cnt`=0, `last_grant`=`num_req-1`, so requester 0 has first priority.
  - `req_ready`=0 (combinational, follows state=IDLE).
- **Reset mid-burst:** the burst aborts and `fifo_wrEn` is 0 in the cycle after the reset edge. Words not yet accepted are not written.
- **Arbitration latency:** 1 cycle. A valid asserted at cycle t from IDLE sees ready at cycle t+1 at the earliest.
- **Write latency:** a word accepted in cycle t appears on `fifo_wrEn`/`fifo_wrData` in cycle t+1.
- **Bubble:** there is one IDLE bubble cycle between consecutive grants.
- **Throughput:** at most `max_burst` words per `max_burst+1` cycles per grant when space allows.
- **Producer rules:** a producer holds `req_data` stable while `req_valid` is high and ready is low. Dropping valid before a transfer forfeits the grant.

## Configuration
- Macro: `FIFO_ARB_STATS_EN`.
- **Defined:** adds output port `stall_count` (16 bits).
  - Counts cycles with state=GRANT, `req_valid[grant_id]`=1 and `!space`.
  - Saturates at 16'hFFFF and is cleared by reset.
- **Undefined:** the port and counter are absent. All other behaviour is identical.

## Test plan
All scenarios use width=8, num_req=4, max_burst=4, depth=8.
1. **Single-requester burst:** only requester 2 valid with 6 words, FIFO empty → grant_id=2; words 1–4 written on consecutive cycles; 1 IDLE bubble; words 5–6 written after regrant.
2. **Fairness:** all 4 requesters continuously valid → grant order 0,1,2,3,0; exactly 4 writes per grant; `fifo_wrEn` never high in IDLE bubble cycles.
3. **Backpressure:** `fifo_data_count`=7, requester 1 valid → one word accepted; next cycle `req_ready`=0 because 7+1=8; ready reasserts the cycle after count drops to 6 with `fifo_wrEn`=0; with `FIFO_ARB_STATS_EN`, `stall_count` increments each stalled cycle.
4. **Valid drop:** requester 3 drops valid after 2 words → release to IDLE; next grant goes to requester 0 if valid.
5. **Reset mid-burst:** reset asserted after word 2 of a burst → next cycle `fifo_wrEn`=0, `busy`=0, `grant_id`=0; the first grant after reset goes to requester 0.
